// File: rtl/num_pkg.sv
// rtl/num_pkg.sv - shared constants and state encoding for the operand-entry sequencer
//
// Holds the FSM state encoding shown on the LEDs, the default operand width
// shared with the 4-bit magnitude comparator, and the default debounce length.
package num_pkg;

    // Default operand width; must match the comparator's A/B inputs.
    localparam int NUM_W = 4;

    // Default debounce length in clock cycles (about 10 ms at 50 MHz).
    localparam int DB_CYCLES_DEF = 500000;

    // Encoding 2'd3 is unused and recovers to S_GET_A.
    typedef enum logic [1:0] {
        S_GET_A = 2'd0,
        S_GET_B = 2'd1,
        S_DONE  = 2'd2
    } num_state_e;

endpackage

// File: rtl/num_load_if.sv
// rtl/num_load_if.sv - operand-entry bus between switches/button, sequencer and comparator
//
// Signals:
//   sw       operand value from the slide switches
//   key      raw push button, active-high, asynchronous to clk
//   clr      synchronous clear, active-high
//   a, b     operands to the comparator
//   ab_valid both operands freshly loaded
//   state    current sequencer state, for the LEDs
// Modports:
//   master   drives sw/key/clr, observes the outputs (board side / bench)
//   slave    the sequencer itself
interface num_load_if
    import num_pkg::*;
#(
    parameter int W = NUM_W
);
    logic [W-1:0] sw;
    logic         key;
    logic         clr;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ab_valid;
    logic [1:0]   state;

    modport master (
        output sw, key, clr,
        input  a, b, ab_valid, state
    );

    modport slave (
        input  sw, key, clr,
        output a, b, ab_valid, state
    );
endinterface

// File: rtl/num_load_key_debounce.sv
// rtl/num_load_key_debounce.sv - synchroniser, debounce and press detect for the load button
//
// Ports:
//   clk      system clock
//   rst      asynchronous, active-high reset
//   key_raw  raw push button, asynchronous to clk
//   press    single-cycle pulse on an accepted release->press transition
// Option macro: NUM_LOAD_DEBOUNCE_EN
//   defined   - the synchronised key must hold its new level for DB_CYCLES
//               edges before the debounced level follows it
//   undefined - the debounced level simply registers the synchronised key,
//               behaving like DB_CYCLES=1; DB_CYCLES is not used
module key_debounce
    import num_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic key_raw,
    output logic press
);

    if (DB_CYCLES < 1) begin : g_bad_db_cycles
        $error("key_debounce: DB_CYCLES must be at least 1");
    end

    logic s1;
    logic s2;
    logic level;
    logic level_d;

    // Two-flop synchroniser for the asynchronous button.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= key_raw;
            s2 <= s1;
        end
    end

`ifdef NUM_LOAD_DEBOUNCE_EN
    // cnt only ever reaches DB_CYCLES-1, so $clog2(DB_CYCLES) bits suffice.
    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic [CW-1:0] cnt;

    // Any return of s2 to the accepted level restarts the count, so a bounce
    // has to settle for a full DB_CYCLES run before it is believed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (s2 == level) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            level <= s2;
            cnt   <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level <= 1'b0;
        end else begin
            level <= s2;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_d <= 1'b0;
        end else begin
            level_d <= level;
        end
    end

    // Rising edge of the accepted level only; a release produces nothing.
    assign press = level & ~level_d;

endmodule

// File: rtl/num_load.sv
// rtl/num_load.sv - two-operand entry sequencer feeding the 4-bit magnitude comparator
//
// Ports:
//   clk  system clock
//   rst  asynchronous, active-high reset
//   bus  num_load_if.slave: sw/key/clr in, a/b/ab_valid/state out
// Each accepted button press loads the switch value: first into a, then into
// b (raising ab_valid); a press after that starts a new pair in a.
// Option macro: NUM_LOAD_DEBOUNCE_EN (see key_debounce).
module num_load
    import num_pkg::*;
#(
    parameter int W         = NUM_W,
    parameter int DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst,
    num_load_if.slave   bus
);

    logic press;

    num_state_e   state_q, state_n;
    logic [W-1:0] a_q, a_n;
    logic [W-1:0] b_q, b_n;
    logic         valid_q, valid_n;

    key_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_key_debounce (
        .clk     (clk),
        .rst     (rst),
        .key_raw (bus.key),
        .press   (press)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_GET_A;
            a_q     <= '0;
            b_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_n;
            a_q     <= a_n;
            b_q     <= b_n;
            valid_q <= valid_n;
        end
    end

    always_comb begin
        state_n = state_q;
        a_n     = a_q;
        b_n     = b_q;
        valid_n = valid_q;

        if (bus.clr) begin
            // clr wins over a coincident press; that press is dropped.
            state_n = S_GET_A;
            a_n     = '0;
            b_n     = '0;
            valid_n = 1'b0;
        end else begin
            case (state_q)
                S_GET_A, S_DONE: begin
                    if (press) begin
                        a_n     = bus.sw;
                        b_n     = '0;
                        valid_n = 1'b0;
                        state_n = S_GET_B;
                    end
                end
                S_GET_B: begin
                    if (press) begin
                        b_n     = bus.sw;
                        valid_n = 1'b1;
                        state_n = S_DONE;
                    end
                end
                default: begin
                    state_n = S_GET_A;
                    a_n     = '0;
                    b_n     = '0;
                    valid_n = 1'b0;
                end
            endcase
        end
    end

    assign bus.a        = a_q;
    assign bus.b        = b_q;
    assign bus.ab_valid = valid_q;
    assign bus.state    = state_q;

endmodule

// File: tb/tb_num_load.sv
// tb/tb_num_load.sv - directed self-checking bench for num_load
module tb_num_load;

`ifdef NUM_LOAD_DEBOUNCE_EN
    localparam int EDB = 4;
`else
    localparam int EDB = 1;
`endif
    // Edges from the first key-high edge to the load edge.
    localparam int LAT = EDB + 3;

    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   miscompares = 0;

    num_load_if #(.W(4)) bus ();

    num_load #(
        .W         (4),
        .DB_CYCLES (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [3:0] ea, input logic [3:0] eb,
                             input logic ev, input logic [1:0] es);
        check_vec({tag, ".a"}, 8'(bus.a), 8'(ea));
        check_vec({tag, ".b"}, 8'(bus.b), 8'(eb));
        check_vec({tag, ".ab_valid"}, 8'(bus.ab_valid), 8'(ev));
        check_vec({tag, ".state"}, 8'(bus.state), 8'(es));
    endtask

    task automatic release_key();
        bus.key = 1'b0;
        repeat (LAT + 4) tick();
    endtask

    initial begin
        rst     = 1'b1;
        bus.sw  = 4'd0;
        bus.key = 1'b0;
        bus.clr = 1'b0;
        tick();
        tick();
        check_out("reset", 4'd0, 4'd0, 1'b0, 2'd0);
        rst = 1'b0;

        // Basic load, first press into a.
        bus.sw  = 4'd9;
        bus.key = 1'b1;
        repeat (LAT - 1) tick();
        check_out("a_preload", 4'd0, 4'd0, 1'b0, 2'd0);
        tick();
        check_out("a_load", 4'd9, 4'd0, 1'b0, 2'd1);
        repeat (3) tick();
        release_key();
        check_out("a_release", 4'd9, 4'd0, 1'b0, 2'd1);

        // Second press into b.
        bus.sw  = 4'd3;
        bus.key = 1'b1;
        repeat (LAT - 1) tick();
        check_out("b_preload", 4'd9, 4'd0, 1'b0, 2'd1);
        tick();
        check_out("b_load", 4'd9, 4'd3, 1'b1, 2'd2);
        bus.sw = 4'd15;
        repeat (3) tick();
        release_key();
        check_out("sw_ignored", 4'd9, 4'd3, 1'b1, 2'd2);

`ifdef NUM_LOAD_DEBOUNCE_EN
        // Glitch of 3 cycles must not be accepted.
        bus.key = 1'b1;
        repeat (3) tick();
        bus.key = 1'b0;
        repeat (12) tick();
        check_out("glitch", 4'd9, 4'd3, 1'b1, 2'd2);
`endif

        // Restart from DONE; exact latency also shows the counter restarted at 0.
        bus.sw  = 4'd12;
        bus.key = 1'b1;
        repeat (LAT - 1) tick();
        check_out("restart_pre", 4'd9, 4'd3, 1'b1, 2'd2);
        tick();
        check_out("restart", 4'd12, 4'd0, 1'b0, 2'd1);
        release_key();

        // clr on the same edge as the press pulse.
        bus.sw  = 4'd5;
        bus.key = 1'b1;
        repeat (LAT - 1) tick();
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
        check_out("clr_press", 4'd0, 4'd0, 1'b0, 2'd0);
        repeat (5) tick();
        check_out("clr_discard", 4'd0, 4'd0, 1'b0, 2'd0);
        release_key();

`ifdef NUM_LOAD_DEBOUNCE_EN
        // Bounce 1,0,1,0 then hold: one press, sw sampled at the load edge.
        bus.sw  = 4'd7;
        bus.key = 1'b1; tick();
        bus.key = 1'b0; tick();
        bus.key = 1'b1; tick();
        bus.key = 1'b0; tick();
        bus.key = 1'b1;
        repeat (LAT - 1) tick();
        check_out("bounce_pre", 4'd0, 4'd0, 1'b0, 2'd0);
        bus.sw = 4'd6;
        tick();
        check_out("bounce_load", 4'd6, 4'd0, 1'b0, 2'd1);
        bus.sw = 4'd1;
        repeat (6) tick();
        check_out("bounce_once", 4'd6, 4'd0, 1'b0, 2'd1);
        release_key();
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
`endif

        // Reset mid-debounce while in GET_B.
        bus.sw  = 4'd5;
        bus.key = 1'b1;
        repeat (LAT) tick();
        check_out("pre_rst_load", 4'd5, 4'd0, 1'b0, 2'd1);
        release_key();
        bus.key = 1'b1;
        repeat (4) tick();
        #2;
        rst = 1'b1;
        #1;
        check_out("async_rst", 4'd0, 4'd0, 1'b0, 2'd0);
        tick();
        tick();
        rst    = 1'b0;
        bus.sw = 4'd10;
        repeat (LAT - 1) tick();
        check_out("post_rst_pre", 4'd0, 4'd0, 1'b0, 2'd0);
        tick();
        check_out("post_rst_load", 4'd10, 4'd0, 1'b0, 2'd1);
        release_key();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
